// File: rtl/fir_wyj_czytnik.sv
// Output-sample drain for the FIR core: converts 21-bit results to Q1.15, buffers them in a FIFO
// for the host and raises irq once a frame is complete. Saturation is enabled by FIR_WYJ_SAT_EN.
module fir_wyj_czytnik #(
    parameter int unsigned WIDTH_IN  = 21,
    parameter int unsigned WIDTH_OUT = 16,
    parameter int unsigned DEPTH     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wyj_wr_i,
    input  logic [WIDTH_IN-1:0]      wyj_data_i,
    input  logic                     fir_done_i,
    input  logic                     rd_en_i,
    output logic [WIDTH_OUT-1:0]     rd_data_o,
    output logic                     rd_valid_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o,
    input  logic                     clr_overflow_i,
    output logic                     irq_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {StIdle, StZbiera, StGotowe} state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        count_q, count_d;
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [WIDTH_OUT-1:0] rd_data_q;
    logic                 rd_valid_q;
    logic                 overflow_q;
    logic [WIDTH_OUT-1:0] mem_q [DEPTH];
    logic [WIDTH_OUT-1:0] conv;
    logic                 rd_acc, wr_acc, ovf_evt;

`ifdef FIR_WYJ_SAT_EN
    // Out of range when the bits above the Q1.15 sign are not a copy of it.
    logic [WIDTH_IN-WIDTH_OUT:0] hi;
    logic                        pos_ovf, neg_ovf;
    assign hi      = wyj_data_i[WIDTH_IN-1:WIDTH_OUT-1];
    assign pos_ovf = ~hi[WIDTH_IN-WIDTH_OUT] & (|hi);
    assign neg_ovf = hi[WIDTH_IN-WIDTH_OUT] & ~(&hi);

    always_comb begin
        conv = wyj_data_i[WIDTH_OUT-1:0];
        if (pos_ovf) begin
            conv = {1'b0, {(WIDTH_OUT-1){1'b1}}};
        end else if (neg_ovf) begin
            conv = {1'b1, {(WIDTH_OUT-1){1'b0}}};
        end
    end
`else
    logic unused_hi;
    assign unused_hi = ^wyj_data_i[WIDTH_IN-1:WIDTH_OUT];
    assign conv      = wyj_data_i[WIDTH_OUT-1:0];
`endif

    // A read accepted in the same cycle frees the slot, so a write to a full FIFO still lands.
    assign rd_acc  = rd_en_i & (count_q != '0);
    assign wr_acc  = wyj_wr_i & ((count_q != CW'(DEPTH)) | rd_acc);
    assign ovf_evt = wyj_wr_i & ~wr_acc;
    assign count_d = count_q + CW'(wr_acc) - CW'(rd_acc);

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= conv;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            rd_valid_q <= rd_acc;
            if (wr_acc) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr_q  <= rd_ptr_q + AW'(1);
                rd_data_q <= mem_q[rd_ptr_q];
            end
            if (ovf_evt) begin
                overflow_q <= 1'b1;
            end else if (clr_overflow_i) begin
                overflow_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame decisions look at the post-write count so a same-cycle sample counts.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (fir_done_i && count_d != '0) begin
                    state_d = StGotowe;
                end else if (wr_acc) begin
                    state_d = StZbiera;
                end
            end
            StZbiera: begin
                if (fir_done_i && count_d != '0) begin
                    state_d = StGotowe;
                end
            end
            StGotowe: begin
                if (count_d == '0) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        irq_o      = (state_q == StGotowe);
        empty_o    = (count_q == '0);
        full_o     = (count_q == CW'(DEPTH));
        count_o    = count_q;
        rd_data_o  = rd_data_q;
        rd_valid_o = rd_valid_q;
        overflow_o = overflow_q;
    end

endmodule

// File: tb/tb_fir_wyj_czytnik.sv
// Bench for fir_wyj_czytnik: expected samples are queued on write and compared on each rd_valid;
// status outputs are compared against a small behavioural model after every cycle.
module tb_fir_wyj_czytnik;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wyj_wr = 1'b0;
    logic [20:0] wyj_data = '0;
    logic        fir_done = 1'b0;
    logic        rd_en = 1'b0;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        empty;
    logic        full;
    logic [3:0]  count;
    logic        overflow;
    logic        clr_overflow = 1'b0;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;
    int sb[$];
    int m_count = 0;
    int m_state = 0;
    int m_last = 0;
    bit m_ovf = 1'b0;

    fir_wyj_czytnik dut (
        .clk            (clk),
        .rst            (rst),
        .wyj_wr_i       (wyj_wr),
        .wyj_data_i     (wyj_data),
        .fir_done_i     (fir_done),
        .rd_en_i        (rd_en),
        .rd_data_o      (rd_data),
        .rd_valid_o     (rd_valid),
        .empty_o        (empty),
        .full_o         (full),
        .count_o        (count),
        .overflow_o     (overflow),
        .clr_overflow_i (clr_overflow),
        .irq_o          (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int conv(input logic [20:0] d);
        int v;
        v = $signed(d);
`ifdef FIR_WYJ_SAT_EN
        if (v > 32767) return 32'h7FFF;
        if (v < -32768) return 32'h8000;
`endif
        return v & 32'hFFFF;
    endfunction

    // Scoreboard: each rd_valid pulse pops the oldest expected sample.
    always @(negedge clk) begin
        if (!rst && rd_valid) begin
            if (sb.size() == 0) begin
                check("spurious_rd_valid", 1, 0);
            end else begin
                m_last = sb.pop_front();
                check("rd_data", int'(rd_data), m_last);
            end
        end
    end

    task automatic check_status(input bit exp_valid);
        check("count", int'(count), m_count);
        check("empty", int'(empty), int'(m_count == 0));
        check("full", int'(full), int'(m_count == DEPTH));
        check("overflow", int'(overflow), int'(m_ovf));
        check("irq", int'(irq), int'(m_state == 2));
        check("rd_valid", int'(rd_valid), int'(exp_valid));
        if (!exp_valid) check("rd_data_hold", int'(rd_data), m_last);
    endtask

    // Called on a negedge; drives one clock of inputs and returns on the following negedge.
    task automatic cycle(input bit wr, input logic [20:0] d, input bit rd, input bit done,
                         input bit clr);
        bit rd_acc, wr_acc;
        wyj_wr = wr; wyj_data = d; rd_en = rd; fir_done = done; clr_overflow = clr;
        rd_acc = rd && (m_count > 0);
        wr_acc = wr && ((m_count < DEPTH) || rd_acc);
        @(negedge clk);
        wyj_wr = 1'b0; rd_en = 1'b0; fir_done = 1'b0; clr_overflow = 1'b0;
        if (wr_acc) sb.push_back(conv(d));
        if (wr && !wr_acc) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        m_count = m_count + int'(wr_acc) - int'(rd_acc);
        case (m_state)
            0: if (done && m_count != 0) m_state = 2; else if (wr_acc) m_state = 1;
            1: if (done && m_count != 0) m_state = 2;
            default: if (m_count == 0) m_state = 0;
        endcase
        check_status(rd_acc);
    endtask

    task automatic wr(input logic [20:0] d);
        cycle(1'b1, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rd();
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic model_reset();
        sb.delete();
        m_count = 0; m_state = 0; m_last = 0; m_ovf = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset and idle
        rst = 1'b1;
        #12;
        check_status(1'b0);
        check("rst_rd_data", int'(rd_data), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rd();
        rd();

        // 2: basic write/read order
        wr(21'h02000);
        wr(21'h04000);
        wr(21'h1FFFFF);
        repeat (3) rd();
        rd();

        // 3: out-of-range conversion
        wr(21'h010000);
        rd();
        wr(21'h1F0000);
        rd();
        wr(21'h007FFF);
        wr(21'h1F8000);
        wr(21'h008000);
        wr(21'h1F7FFF);
        repeat (4) rd();

        // 4: full, overflow, simultaneous read/write while full, clear
        for (int i = 0; i < DEPTH; i++) wr(21'(i * 21'h111));
        wr(21'h00ABC);
        cycle(1'b1, 21'h00DEF, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        repeat (DEPTH + 1) rd();

        // overflow set wins over clear
        for (int i = 0; i < DEPTH; i++) wr(21'(i + 5));
        cycle(1'b1, 21'h00123, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        repeat (DEPTH) rd();

        // 5: frame done and irq drain
        wr(21'h00011);
        wr(21'h00022);
        wr(21'h00033);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
        wr(21'h00044);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
        repeat (4) rd();
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 21'h00055, 1'b0, 1'b1, 1'b0);
        rd();
        cycle(1'b1, 21'h00066, 1'b1, 1'b0, 1'b0);
        rd();

        // 6: reset mid-drain
        for (int i = 0; i < 5; i++) wr(21'(21'h00100 + i));
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
        rd();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_status(1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        wr(21'h00777);
        rd();

        // random traffic
        for (int i = 0; i < 300; i++) begin
            cycle(bit'($urandom_range(0, 1)), 21'($urandom()), bit'($urandom_range(0, 1)),
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0));
        end
        while (m_count > 0) rd();
        rd();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
